rr_burst_arbiter: RTL and testbench
===================================

Name: rr_burst_arbiter

Overview:
- Four-requester round-robin arbiter that shares one burst resource between requesters a..d.
- Each grant is a tenure of up to BURST_LEN cycles. A tenure ends early if the owner drops its request.
- Drives the ga..gd grant lines consumed by the datapath. Its request/grant protocol is the one the team's arbiter assertion set checks.

Parameters:
- BURST_LEN, 16: maximum grant tenure in cycles; legal range 2..31.
- CNT_W, 5: width of the tenure counter; must hold BURST_LEN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ra, rb, rc, rd  input  1 each  request from requesters a..d; level, held for the whole tenure.
- ga, gb, gc, gd  output  1 each  grant; registered; at most one high.
- owner  output  2  index of the current or last owner (0=a .. 3=d); registered.
- busy  output  1  high while any grant is high; registered.
- burst_done  output  1  one-cycle pulse in the cycle after a grant falls; registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - ga..gd=0, busy=0, burst_done=0, owner=0.
  - Round-robin pointer = 3, so requester a has highest priority first.
  - Counter=0, state=IDLE.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If any request is high at a rising edge, select the winner, register its grant, set owner, set counter=1, go to GRANT.
  - Winner is the first requester with request high, searching from pointer+1 and wrapping mod 4.
  - Latency: request seen at edge N gives grant high after edge N (visible in cycle N+1). Zero-cycle grant is not allowed.
- GRANT:
  - Owner request high and counter<BURST_LEN: hold grant, counter+1.
  - Owner request low: clear grant at this edge (early release), go to GAP.
  - Counter==BURST_LEN: clear grant (tenure expiry), go to GAP, even if the request is still high.
  - A full tenure therefore holds the grant exactly BURST_LEN cycles.
  - Requests from non-owners are ignored.
- GAP:
  - Exactly one cycle with all grants 0. burst_done=1 in this cycle.
  - Pointer updates to owner. Next edge returns to IDLE.
  - Arbitration restarts from IDLE, so the minimum idle time between two grants is 2 cycles. No back-to-back grants.
- Tie-breaking:
  - Simultaneous requests resolve by the round-robin order only.
  - A requester still requesting after expiry loses to any other pending requester. It is regranted only after the others, or immediately if it is alone.
- busy = OR of grants, registered together with the grants; never high in IDLE or GAP.
- Counter saturates; it never wraps within a tenure.
- Reset mid-tenure: all outputs drop asynchronously; the pointer returns to 3.
- Invariants:
  - Grants are one-hot or zero.
  - A grant rises only from IDLE.
  - owner stays stable while busy=1.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: winner is the lowest index with request high (a>b>c>d). The pointer is not used or updated. Tenure, GAP and latency rules are unchanged.
- Undefined: round-robin as above.

Test Plan:
- Reset release, then ra=1 held for 40 cycles, others 0:
  - ga rises 1 cycle after first sampled ra and stays high exactly 16 cycles, then falls.
  - burst_done pulses once; after a 2-cycle gap ga rises again.
- ra=rb=rc=rd=1 held continuously:
  - Grants go a,b,c,d,a, each 16 cycles with 2 idle cycles between.
  - owner reads 0,1,2,3,0; never two grants high at once.
- rb=1 for 5 cycles then 0:
  - gb high 5 cycles, falling the edge after rb falls; then burst_done=1 and busy=0.
- reset driven low in cycle 7 of a gc tenure:
  - gc, busy and owner go to 0 immediately.
  - After release with rb=rc=1, gb wins first (pointer reset to 3, search starts at a).
- With ARB_FIXED_PRIO_EN defined and ra=rd=1 held:
  - Only ga is ever granted, repeated 16-cycle tenures with 2-cycle gaps; gd stays 0.
- rd=1 alone after a gd tenure expires:
  - gd is regranted after the 2-cycle gap; total low time on gd is 2 cycles.

Source files
------------

// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter: four-requester arbiter for a shared burst resource.
// Each grant is a tenure of up to BURST_LEN cycles. It is followed by one GAP
// cycle (burst_done pulse) and one IDLE arbitration cycle.
// Optional build macro ARB_FIXED_PRIO_EN: fixed priority a>b>c>d replaces round-robin.
module rr_burst_arbiter #(
   parameter int unsigned BURST_LEN = 16,
   parameter int unsigned CNT_W     = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ra,
   input  logic       rb,
   input  logic       rc,
   input  logic       rd,
   output logic       ga,
   output logic       gb,
   output logic       gc,
   output logic       gd,
   output logic [1:0] owner,
   output logic       busy,
   output logic       burst_done
);

   localparam int unsigned N_REQ = 4;
   localparam int unsigned IDX_W = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [N_REQ-1:0]   req_c;
   logic [IDX_W-1:0]   win_c;
   logic               any_req_c;
`ifndef ARB_FIXED_PRIO_EN
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   idx_c;
`endif

   assign req_c = {rd, rc, rb, ra};

   // Winner select: the last match in a descending scan is the highest-priority one.
   always_comb begin
      win_c     = '0;
      any_req_c = |req_c;
`ifdef ARB_FIXED_PRIO_EN
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_c[i]) win_c = IDX_W'(i);
      end
`else
      idx_c = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         idx_c = ptr_q + IDX_W'(i);
         if (req_c[idx_c]) win_c = idx_c;
      end
`endif
   end

   // Next-state and registered-output values.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (any_req_c) begin
               gnt_d   = N_REQ'(1) << win_c;
               owner_d = win_c;
               cnt_d   = CNT_W'(1);
               state_d = GRANT;
            end
         end
         GRANT: begin
            // Early release or tenure expiry both end the grant at this edge.
            if (!req_c[owner_q] || (cnt_q >= CNT_W'(BURST_LEN))) begin
               gnt_d   = '0;
               done_d  = 1'b1;
               state_d = GAP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         GAP: begin
`ifndef ARB_FIXED_PRIO_EN
            ptr_d = owner_q;
`endif
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            gnt_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
      busy_d = |gnt_d;
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
`ifndef ARB_FIXED_PRIO_EN
         ptr_q   <= IDX_W'(3);
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
`ifndef ARB_FIXED_PRIO_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   assign ga         = gnt_q[0];
   assign gb         = gnt_q[1];
   assign gc         = gnt_q[2];
   assign gd         = gnt_q[3];
   assign owner      = owner_q;
   assign busy       = busy_q;
   assign burst_done = done_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Scoreboard bench for rr_burst_arbiter. The stimulus pushes the expected tenures
// {owner, length, preceding gap}. A negedge monitor pops one at each grant rise.
module tb_rr_burst_arbiter;

   typedef struct {
      int owner;
      int len;
      int gap;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       ra, rb, rc, rd;
   logic       ga, gb, gc, gd;
   logic [1:0] owner;
   logic       busy;
   logic       burst_done;

   exp_t       sbq[$];
   exp_t       cur;
   int         total;
   int         bad;
   int         hi_cnt;
   int         low_cnt;
   bit         active;
   bit         done;
   bit         end_checked;
   logic [3:0] g;
   logic [3:0] prev_g;
   logic       exp_bd;

   rr_burst_arbiter #(.BURST_LEN(16), .CNT_W(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .ra         (ra),
      .rb         (rb),
      .rc         (rc),
      .rd         (rd),
      .ga         (ga),
      .gb         (gb),
      .gc         (gc),
      .gd         (gd),
      .owner      (owner),
      .busy       (busy),
      .burst_done (burst_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void push(input int o, input int l, input int gp);
      exp_t e;
      e.owner = o;
      e.len   = l;
      e.gap   = gp;
      sbq.push_back(e);
   endfunction

   // Monitor: per-cycle invariants plus tenure scoreboard.
   initial begin
      total = 0; bad = 0; hi_cnt = 0; low_cnt = 0;
      active = 1'b0; end_checked = 1'b0; prev_g = '0;
      cur.owner = 0; cur.len = 0; cur.gap = 0;
      forever begin
         @(negedge clk);
         g      = {gd, gc, gb, ga};
         exp_bd = (prev_g != 4'd0) && (g == 4'd0) && reset;
         check("onehot", int'($countones(g) <= 1), 1);
         check("busy", int'(busy), int'(g != 4'd0));
         check("burst_done", int'(burst_done), int'(exp_bd));
         if (!reset) begin
            check("reset_owner", int'(owner), 0);
            check("reset_grant", int'(g), 0);
         end
         if (!active && g != 4'd0) begin
            if (sbq.size() == 0) begin
               check("unexpected_grant", int'(owner), -1);
               cur.owner = int'(owner); cur.len = -1; cur.gap = -1;
            end else begin
               cur = sbq.pop_front();
               check("grant_owner", int'(owner), cur.owner);
               check("grant_line", int'(g), 1 << cur.owner);
               if (cur.gap >= 0) check("gap", low_cnt, cur.gap);
            end
            active = 1'b1;
            hi_cnt = 1;
         end else if (active && g != 4'd0) begin
            hi_cnt++;
            check("owner_stable", int'(owner), cur.owner);
         end else if (active) begin
            check("tenure_len", hi_cnt, cur.len);
            active  = 1'b0;
            low_cnt = 1;
         end else begin
            low_cnt++;
         end
         prev_g = g;
         if (done && !end_checked) begin
            check("queue_empty", sbq.size(), 0);
            check("idle_at_end", int'(active), 0);
            end_checked = 1'b1;
         end
      end
   end

   // Stimulus: directed scenarios, each pushing its hand-computed tenures.
   initial begin
      done = 1'b0;
      reset = 1'b0;
      ra = 1'b0; rb = 1'b0; rc = 1'b0; rd = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1 reset = 1'b1;
      @(posedge clk); #1;

      // ra alone for 40 cycles: 16, gap 2, 16, gap 2, then 4 before ra drops.
      push(0, 16, -1); push(0, 16, 2); push(0, 4, 2);
      ra = 1'b1;
      repeat (40) @(posedge clk);
      #1 ra = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      // rb for 5 cycles: early release after 5 grant cycles.
      push(1, 5, -1);
      rb = 1'b1;
      repeat (5) @(posedge clk);
      #1 rb = 1'b0;
      repeat (5) @(posedge clk);

`ifdef ARB_FIXED_PRIO_EN
      #1;
      // Fixed priority, ra and rd held: only a is ever granted.
      push(0, 16, -1); push(0, 16, 2); push(0, 16, 2);
      ra = 1'b1; rd = 1'b1;
      repeat (52) @(posedge clk);
      #1 ra = 1'b0; rd = 1'b0;
      repeat (5) @(posedge clk);
`else
      // Idle reset restores the pointer to 3, then all four requesters are held.
      @(negedge clk); #1 reset = 1'b0;
      @(negedge clk); #1 reset = 1'b1;
      @(posedge clk); #1;
      push(0, 16, -1); push(1, 16, 2); push(2, 16, 2); push(3, 16, 2); push(0, 16, 2);
      ra = 1'b1; rb = 1'b1; rc = 1'b1; rd = 1'b1;
      repeat (88) @(posedge clk);
      #1 ra = 1'b0; rb = 1'b0; rc = 1'b0; rd = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      // gc tenure cut by reset in its 7th cycle; afterwards b beats c from pointer 3.
      push(2, 7, -1); push(1, 16, -1); push(2, 16, 2);
      rc = 1'b1;
      repeat (7) @(posedge clk);
      @(negedge clk); #1 reset = 1'b0;
      rb = 1'b1;
      repeat (2) @(negedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      repeat (33) @(posedge clk);
      #1 rb = 1'b0; rc = 1'b0;
      repeat (5) @(posedge clk);
`endif
      #1;

      // rd alone: regranted after expiry with exactly two low cycles.
      push(3, 16, -1); push(3, 16, 2);
      rd = 1'b1;
      repeat (34) @(posedge clk);
      #1 rd = 1'b0;
      repeat (5) @(posedge clk);

      done = 1'b1;
      repeat (4) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
